// File: rtl/heap_topk_ctrl.sv
// rtl/heap_topk_ctrl.sv - frame sequencer that streams candidates into a heap sorter and drains its top-K
module heap_topk_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int KEY_WIDTH    = 16,
   parameter int NLEVELS      = 2,
   parameter int CNT_WIDTH    = 16,
   parameter int TAIL_CYCLES  = 4,
   parameter int DRAIN_CYCLES = 2 * ((1 << (NLEVELS + 1)) - 1) + 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   output logic                             busy,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [KEY_WIDTH-1:0]             s_key,
   input  logic [DATA_WIDTH-2-KEY_WIDTH-1:0] s_payload,
   input  logic                             s_last,
   output logic [DATA_WIDTH-1:0]            heap_din,
   output logic                             heap_en,
   output logic                             heap_init,
   output logic                             heap_flush,
   input  logic [DATA_WIDTH-1:0]            heap_dout,
   input  logic                             heap_valid,
   output logic                             m_valid,
   output logic [DATA_WIDTH-3:0]            m_data,
   output logic [CNT_WIDTH-1:0]             m_idx,
   output logic                             done,
   output logic [CNT_WIDTH-1:0]             in_cnt,
   output logic [CNT_WIDTH-1:0]             out_cnt
);

   localparam int HEAP_SIZE = (1 << (NLEVELS + 1)) - 1;
   localparam logic [15:0] TAIL_LAST  = 16'(TAIL_CYCLES - 1);
   localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, INIT, SETTLE, STREAM, TAIL, FLUSH_REQ, DRAIN, DONE
   } state_t;

   state_t      state;
   logic [15:0] phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         busy       <= 1'b0;
         s_ready    <= 1'b0;
         heap_din   <= '0;
         heap_en    <= 1'b0;
         heap_init  <= 1'b0;
         heap_flush <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_idx      <= '0;
         done       <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
      end else begin
         heap_en    <= 1'b0;
         heap_init  <= 1'b0;
         heap_flush <= 1'b0;
         m_valid    <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= INIT;
                  heap_init <= 1'b1;
                  busy      <= 1'b1;
                  in_cnt    <= '0;
                  out_cnt   <= '0;
                  m_idx     <= '0;
               end
            end
            INIT: state <= SETTLE;
            SETTLE: begin
               state   <= STREAM;
               s_ready <= 1'b1;
            end
            STREAM: begin
               // sorter evictions arriving here are intentionally ignored
               if (s_valid && s_ready) begin
                  heap_en  <= 1'b1;
                  heap_din <= {2'b00, s_payload, s_key};
                  if (in_cnt != '1)
                     in_cnt <= in_cnt + CNT_WIDTH'(1);
                  if (s_last) begin
                     s_ready <= 1'b0;
                     state   <= TAIL;
                     phase   <= '0;
                  end
               end
            end
            TAIL: begin
               if (phase == TAIL_LAST) begin
                  state      <= FLUSH_REQ;
                  heap_flush <= 1'b1;
               end else begin
                  phase <= phase + 16'd1;
               end
            end
            FLUSH_REQ: begin
               state <= DRAIN;
               phase <= '0;
            end
            DRAIN: begin
               if (heap_valid) begin
                  m_valid <= 1'b1;
                  m_data  <= heap_dout[DATA_WIDTH-3:0];
                  m_idx   <= out_cnt;
                  out_cnt <= out_cnt + CNT_WIDTH'(1);
               end
               if (phase == DRAIN_LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  phase <= phase + 16'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // HEAP_SIZE documents the retained depth; the sorter enforces it
   logic unused_ok;
   assign unused_ok = (HEAP_SIZE > 0) ? 1'b0 : heap_dout[DATA_WIDTH-1];

endmodule

// File: tb/tb_heap_topk_ctrl.sv
// tb/tb_heap_topk_ctrl.sv - scoreboard bench for heap_topk_ctrl with a behavioural heap sorter
module tb_heap_topk_ctrl;

   localparam int DW = 32, KW = 16, PW = DW - 2 - KW, CW = 16, HS = 7;

   logic          clk, rst, start, busy, s_valid, s_ready, s_last;
   logic [KW-1:0] s_key;
   logic [PW-1:0] s_payload;
   logic [DW-1:0] heap_din, heap_dout;
   logic          heap_en, heap_init, heap_flush, heap_valid;
   logic          m_valid, done;
   logic [DW-3:0] m_data;
   logic [CW-1:0] m_idx, in_cnt, out_cnt;

   heap_topk_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_payload(s_payload), .s_last(s_last),
      .heap_din(heap_din), .heap_en(heap_en), .heap_init(heap_init), .heap_flush(heap_flush),
      .heap_dout(heap_dout), .heap_valid(heap_valid),
      .m_valid(m_valid), .m_data(m_data), .m_idx(m_idx), .done(done),
      .in_cnt(in_cnt), .out_cnt(out_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int init_cnt = 0, flush_cnt = 0, en_cnt = 0, done_cnt = 0;
   logic [45:0] exp_q[$];
   int fk[$];
   int fp[$];

   // behavioural sorter: keeps the HS largest keys, evicts the smallest, flushes ascending
   logic [DW-1:0] store[$];
   logic [DW-1:0] flush_q[$];

   function automatic int min_pos();
      int m = 0;
      for (int i = 1; i < store.size(); i++)
         if (store[i][KW-1:0] < store[m][KW-1:0]) m = i;
      return m;
   endfunction

   initial begin
      heap_valid = 1'b0;
      heap_dout  = '0;
   end

   always @(posedge clk) begin
      int mi;
      heap_valid <= 1'b0;
      if (heap_init) begin
         store.delete();
         flush_q.delete();
      end else if (heap_en) begin
         store.push_back(heap_din);
         if (store.size() > HS) begin
            mi = min_pos();
            heap_valid <= 1'b1;
            heap_dout  <= store[mi];
            store.delete(mi);
         end
      end else if (heap_flush) begin
         while (store.size() > 0) begin
            mi = min_pos();
            flush_q.push_back(store[mi]);
            store.delete(mi);
         end
      end else if (flush_q.size() > 0) begin
         heap_valid <= 1'b1;
         heap_dout  <= flush_q.pop_front();
      end
   end

   always @(negedge clk) begin
      logic [45:0] e;
      if (heap_init) init_cnt++;
      if (heap_flush) flush_cnt++;
      if (heap_en) en_cnt++;
      if (done) done_cnt++;
      if (heap_en || heap_flush || heap_init) begin
         checks++;
         if ((heap_en && heap_flush) || (heap_init && (heap_en || heap_flush))) begin
            errors++;
            $display("FAIL strobe_overlap: en=%0b init=%0b flush=%0b, required at most one", heap_en, heap_init, heap_flush);
         end
      end
      if (heap_en) begin
         checks++;
         if (heap_din[DW-1:DW-2] !== 2'b00) begin
            errors++;
            $display("FAIL heap_din_flag: got %b, required 00", heap_din[DW-1:DW-2]);
         end
      end
      if (m_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL m_unexpected: got data=%h idx=%0d, required no output", m_data, m_idx);
         end else begin
            e = exp_q.pop_front();
            if ({m_data, m_idx} !== e) begin
               errors++;
               $display("FAIL m_out: got key=%0d pay=%h idx=%0d, required key=%0d pay=%h idx=%0d",
                        m_data[KW-1:0], m_data[DW-3:KW], m_idx, e[31:16], e[45:32], e[15:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      int t = 0;
      ok = 1'b1;
      while (!s_ready) begin
         tick();
         t++;
         if (t > 50) begin
            ok = 1'b0;
            errors++;
            $display("FAIL ready_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, t);
            return;
         end
      end
   endtask

   // runs fk/fp as one frame; start is re-pulsed alongside beat restart_beat (if >= 0)
   task automatic run_frame(input string name, input int restart_beat);
      int n, k, i0, f0, e0, d0, t;
      int sk[$];
      int sp[$];
      bit ok;
      n = fk.size();
      sk = fk;
      sp = fp;
      for (int i = 0; i < n; i++)
         for (int j = i + 1; j < n; j++)
            if (sk[j] > sk[i]) begin
               t = sk[i]; sk[i] = sk[j]; sk[j] = t;
               t = sp[i]; sp[i] = sp[j]; sp[j] = t;
            end
      k = (n < HS) ? n : HS;
      for (int r = 0; r < k; r++)
         exp_q.push_back({14'(sp[k-1-r]), 16'(sk[k-1-r]), 16'(r)});
      i0 = init_cnt; f0 = flush_cnt; e0 = en_cnt; d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_ready(ok);
      for (int b = 0; b < n && ok; b++) begin
         s_valid   = 1'b1;
         s_key     = KW'(fk[b]);
         s_payload = PW'(fp[b]);
         s_last    = (b == n - 1);
         if (b == restart_beat) start = 1'b1;
         wait_ready(ok);
         tick();
         start = 1'b0;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      t = 0;
      while (!done && t < 300) begin
         tick();
         t++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s done_timeout: done=%0b after %0d cycles, required 1", name, done, t);
      end
      tick();
      checks++;
      if (in_cnt !== CW'(n)) begin
         errors++;
         $display("FAIL %s in_cnt: got %0d, required %0d", name, in_cnt, n);
      end
      checks++;
      if (out_cnt !== CW'(k)) begin
         errors++;
         $display("FAIL %s out_cnt: got %0d, required %0d", name, out_cnt, k);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s missing_outputs: %0d outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL %s post_done: busy=%0b done=%0b, required 0 0", name, busy, done);
      end
      checks++;
      if ((done_cnt - d0) != 1 || (init_cnt - i0) != 1 || (flush_cnt - f0) != 1 || (en_cnt - e0) != n) begin
         errors++;
         $display("FAIL %s pulses: done=%0d init=%0d flush=%0d en=%0d, required 1 1 1 %0d",
                  name, done_cnt - d0, init_cnt - i0, flush_cnt - f0, en_cnt - e0, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({busy, s_ready, heap_en, heap_init, heap_flush, m_valid, done, heap_din, m_data, m_idx, in_cnt, out_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%0b s_ready=%0b in_cnt=%0d out_cnt=%0d, required all 0", busy, s_ready, in_cnt, out_cnt);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ascending();
      fk.delete(); fp.delete();
      for (int i = 1; i <= 10; i++) begin
         fk.push_back(i);
         fp.push_back(i + 16'h100);
      end
      run_frame("ascending", -1);
   endtask

   task automatic test_payload();
      fk = '{50, 20, 30};
      fp = '{'hA, 'hB, 'hC};
      run_frame("payload", -1);
   endtask

   task automatic test_single();
      fk = '{5};
      fp = '{'h3};
      run_frame("single", -1);
   endtask

   task automatic test_idle_guard();
      int e0 = en_cnt;
      s_valid = 1'b1;
      s_key   = 16'd99;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %0b, required 0", s_ready);
         end
      end
      s_valid = 1'b0;
      checks++;
      if (en_cnt != e0) begin
         errors++;
         $display("FAIL idle_heap_en: got %0d inserts, required 0", en_cnt - e0);
      end
      fk = '{7, 3, 8};
      fp = '{1, 2, 3};
      run_frame("restart_ignored", 1);
   endtask

   task automatic test_reset_mid();
      bit ok;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_ready(ok);
      s_valid = 1'b1; s_key = 16'd100; s_payload = '0; s_last = 1'b0;
      tick();
      s_key = 16'd200;
      tick();
      s_valid = 1'b0;
      rst = 1'b1;
      tick();
      checks++;
      if ({busy, s_ready, heap_en, heap_init, heap_flush, m_valid, done, heap_din, m_data, m_idx, in_cnt, out_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid: busy=%0b s_ready=%0b heap_en=%0b in_cnt=%0d, required all 0", busy, s_ready, heap_en, in_cnt);
      end
      rst = 1'b0;
      tick();
      fk = '{1, 2};
      fp = '{4, 5};
      run_frame("after_reset", -1);
   endtask

   task automatic test_back_to_back();
      fk.delete(); fp.delete();
      for (int i = 9; i >= 1; i--) begin
         fk.push_back(i);
         fp.push_back(i * 3);
      end
      run_frame("frame_a", -1);
      fk = '{3, 1};
      fp = '{'h11, 'h22};
      run_frame("frame_b", -1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_key = '0; s_payload = '0;
      test_reset();
      test_ascending();
      test_payload();
      test_single();
      test_idle_guard();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
